// File: rtl/pio_sw_pkg.sv
// Shared constants for the switch PIO: register map, edge-mode encodings and
// the edge-event function.
package pio_sw_pkg;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'd0,
    EDGE_FALL = 2'd1,
    EDGE_ANY  = 2'd2
  } edge_mode_e;

  function automatic logic [31:0] edge_fn(input logic [31:0] cur,
                                          input logic [31:0] prv,
                                          input int          mode);
    if (mode == int'(EDGE_RISE))      edge_fn = cur & ~prv;
    else if (mode == int'(EDGE_FALL)) edge_fn = ~cur & prv;
    else                              edge_fn = cur ^ prv;
  endfunction

endpackage

// File: rtl/pio_sw_debounce.sv
// Switch debouncer: a shared prescaler samples each synchronised bit into a
// 3-deep history; the output bit follows once all three samples agree.
module pio_sw_debounce #(
  parameter int WIDTH  = 18,
  parameter int CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] db_o
);

  localparam int CW = $clog2(CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick;

  assign tick  = (cnt_q == CW'(CYCLES - 1));
  assign cnt_d = tick ? '0 : cnt_q + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic [2:0] hist_q;
    logic       db_q;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        hist_q <= '0;
        db_q   <= 1'b0;
      end else begin
        if (tick) hist_q <= {hist_q[1:0], din_i[i]};
        // Hold the last agreed value while the history is mixed
        if (&hist_q)       db_q <= 1'b1;
        else if (~|hist_q) db_q <= 1'b0;
      end
    end

    assign db_o[i] = db_q;
  end

endmodule

// File: rtl/pio_sw_irq.sv
// Avalon-MM input PIO: synchroniser, optional debounce (PIO_SW_DEBOUNCE_EN),
// edge capture with RW1C clear, interrupt mask and level IRQ.
module pio_sw_irq
  import pio_sw_pkg::*;
#(
  parameter int WIDTH           = 18,
  parameter int EDGE_MODE       = 2,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] s1_q, s2_q, data, prev_q;
  logic [WIDTH-1:0] ec_q, ec_d, mask_q, mask_d, clr, edge_ev;
  logic [31:0]      edge_w, readdata_q, readdata_d;
  logic             wr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= in_port;
      s2_q <= s1_q;
    end
  end

`ifdef PIO_SW_DEBOUNCE_EN
  pio_sw_debounce #(
    .WIDTH  (WIDTH),
    .CYCLES (DEBOUNCE_CYCLES)
  ) u_db (
    .clk   (clk),
    .reset (reset),
    .din_i (s2_q),
    .db_o  (data)
  );
`else
  assign data = s2_q;
`endif

  assign wr = chipselect & ~write_n;

  always_comb begin
    clr    = '0;
    mask_d = mask_q;
    if (wr && address == ADDR_EDGE) clr    = writedata[WIDTH-1:0];
    if (wr && address == ADDR_MASK) mask_d = writedata[WIDTH-1:0];
    edge_w  = edge_fn(32'(data), 32'(prev_q), EDGE_MODE);
    edge_ev = edge_w[WIDTH-1:0];
    // A new edge wins over a clear landing in the same cycle
    ec_d    = (ec_q & ~clr) | edge_ev;
    unique case (address)
      ADDR_DATA: readdata_d = 32'(data);
      ADDR_MASK: readdata_d = 32'(mask_q);
      ADDR_EDGE: readdata_d = 32'(ec_q);
      default:   readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q     <= '0;
      ec_q       <= '0;
      mask_q     <= '0;
      readdata_q <= '0;
    end else begin
      prev_q     <= data;
      ec_q       <= ec_d;
      mask_q     <= mask_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(ec_q & mask_q);

endmodule
